// File: rtl/noc_pkg.sv
// Shared router definitions: port codes, router geometry and allocator FSM state.
package noc_pkg;

    localparam int unsigned NUM_PORTS       = 5;
    localparam int unsigned SEL_W           = 3;
    localparam int unsigned WDOG_CYCLES_DEF = 64;

    typedef enum logic [2:0] {
        NORTH = 3'd0,
        SOUTH = 3'd1,
        EAST  = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } port_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Next port index, wrapping LOCAL back to NORTH.
    function automatic logic [SEL_W-1:0] port_inc(input logic [SEL_W-1:0] p);
        return (p == SEL_W'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/out_port_arb.sv
// Single-output wormhole arbiter: round-robin grant on head flit, lock until tail.
// Optional idle-owner watchdog under macro ARB_WDOG_EN.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   valid_i          per-input FIFO non-empty
//   dest_i           per-input 3-bit destination codes
//   tail_i           per-input tail flag of the head-of-FIFO flit
//   owned_i          inputs already locked to some output
//   out_ready_i      this output can accept a flit
//   owner_oh_c       one-hot owner while locked (comb)
//   xfer_c           flit moves this cycle (comb)
//   sel_c            crossbar select = owner (comb)
//   busy_c           output locked (comb)
//   wdog_err_o       registered one-cycle forced-release pulse
module out_port_arb
    import noc_pkg::*;
#(
    parameter int unsigned PORT_ID = 0
`ifdef ARB_WDOG_EN
    , parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
`endif
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_PORTS-1:0]       valid_i,
    input  logic [NUM_PORTS*SEL_W-1:0] dest_i,
    input  logic [NUM_PORTS-1:0]       tail_i,
    input  logic [NUM_PORTS-1:0]       owned_i,
    input  logic                       out_ready_i,
    output logic [NUM_PORTS-1:0]       owner_oh_c,
    output logic                       xfer_c,
    output logic [SEL_W-1:0]           sel_c,
    output logic                       busy_c,
    output logic                       wdog_err_o
);

    arb_state_e           r_state, w_state_nxt;
    logic [SEL_W-1:0]     r_owner, w_owner_nxt;
    logic [SEL_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_PORTS-1:0] w_req;
    logic                 w_grant_found;
    logic [SEL_W-1:0]     w_grant;

`ifdef ARB_WDOG_EN
    localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_wdog_err, w_wdog_err_nxt;
`endif

    // Eligible heads: addressed here and not already holding another output.
    always_comb begin : req_decode
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_req[p] = valid_i[p] && !owned_i[p]
                       && (dest_i[p*SEL_W +: SEL_W] == SEL_W'(PORT_ID));
        end
    end

    // First requester at or after the round-robin pointer.
    always_comb begin : rr_search
        int unsigned idx;
        w_grant_found = 1'b0;
        w_grant       = '0;
        idx           = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!w_grant_found && w_req[idx[SEL_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant       = idx[SEL_W-1:0];
            end
        end
    end

    // Crossbar/dequeue controls depend only on the registered lock.
    always_comb begin : lock_outputs
        busy_c     = 1'b0;
        sel_c      = '0;
        owner_oh_c = '0;
        xfer_c     = 1'b0;
        if (r_state == ARB_LOCKED) begin
            busy_c     = 1'b1;
            sel_c      = r_owner;
            owner_oh_c = NUM_PORTS'(1) << r_owner;
            xfer_c     = valid_i[r_owner] && out_ready_i;
        end
    end

    // Next-state logic.
    always_comb begin : fsm_next
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
`ifdef ARB_WDOG_EN
        w_cnt_nxt      = r_cnt;
        w_wdog_err_nxt = 1'b0;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_found) begin
                    w_state_nxt = ARB_LOCKED;
                    w_owner_nxt = w_grant;
`ifdef ARB_WDOG_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ARB_LOCKED: begin
                if (xfer_c && tail_i[r_owner]) begin
                    w_state_nxt  = ARB_IDLE;
                    w_rr_ptr_nxt = port_inc(r_owner);
                end
`ifdef ARB_WDOG_EN
                if (xfer_c) begin
                    w_cnt_nxt = '0;
                end else if (!valid_i[r_owner]) begin
                    if (r_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
                        w_state_nxt    = ARB_IDLE;
                        w_rr_ptr_nxt   = port_inc(r_owner);
                        w_wdog_err_nxt = 1'b1;
                        w_cnt_nxt      = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`endif
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

`ifdef ARB_WDOG_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt      <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_wdog_err <= w_wdog_err_nxt;
        end
    end
    assign wdog_err_o = r_wdog_err;
`else
    assign wdog_err_o = 1'b0;
`endif

endmodule

// File: rtl/switch_alloc.sv
// Wormhole switch allocator for the 5-port mesh router (N0,S1,E2,W3,L4).
// One out_port_arb per output; optional watchdog under macro ARB_WDOG_EN.
// Ports:
//   clk_i, rst_n_i  router clock, async active-low reset
//   valid_i[5]      input FIFO non-empty
//   dest_i[15]      dest_i[3p+:3] = output code for input p (head flit)
//   tail_i[5]       head-of-FIFO flit is a tail
//   out_ready_i[5]  downstream of output o accepts a flit
//   deq_o[5]        pop input FIFO p
//   out_valid_o[5]  flit presented on output o
//   out_sel_o[15]   out_sel_o[3o+:3] = input driving output o
//   busy_o[5]       output o locked to a packet
//   wdog_err_o[5]   output o force-released (0 without ARB_WDOG_EN)
module switch_alloc
    import noc_pkg::*;
`ifdef ARB_WDOG_EN
#(
    parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
)
`endif
(
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_PORTS-1:0]       valid_i,
    input  logic [NUM_PORTS*SEL_W-1:0] dest_i,
    input  logic [NUM_PORTS-1:0]       tail_i,
    input  logic [NUM_PORTS-1:0]       out_ready_i,
    output logic [NUM_PORTS-1:0]       deq_o,
    output logic [NUM_PORTS-1:0]       out_valid_o,
    output logic [NUM_PORTS*SEL_W-1:0] out_sel_o,
    output logic [NUM_PORTS-1:0]       busy_o,
    output logic [NUM_PORTS-1:0]       wdog_err_o
);

    logic [NUM_PORTS-1:0] w_owner_oh [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_owned;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        out_port_arb #(
            .PORT_ID     (o)
`ifdef ARB_WDOG_EN
            , .WDOG_CYCLES (WDOG_CYCLES)
`endif
        ) u_arb (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .valid_i     (valid_i),
            .dest_i      (dest_i),
            .tail_i      (tail_i),
            .owned_i     (w_owned),
            .out_ready_i (out_ready_i[o]),
            .owner_oh_c  (w_owner_oh[o]),
            .xfer_c      (out_valid_o[o]),
            .sel_c       (out_sel_o[o*SEL_W +: SEL_W]),
            .busy_c      (busy_o[o]),
            .wdog_err_o  (wdog_err_o[o])
        );
    end

    // An input owns at most one output, so the OR never merges two dequeues.
    always_comb begin : owner_merge
        w_owned = '0;
        deq_o   = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            w_owned = w_owned | w_owner_oh[o];
            if (out_valid_o[o]) deq_o = deq_o | w_owner_oh[o];
        end
    end

endmodule

// File: tb/tb_switch_alloc.sv
// Directed bench for switch_alloc with a per-cycle expected-output scoreboard.
module tb_switch_alloc;
    import noc_pkg::*;

    logic        clk_i;
    logic        rst_n_i;
    logic [4:0]  valid_i;
    logic [14:0] dest_i;
    logic [4:0]  tail_i;
    logic [4:0]  out_ready_i;
    logic [4:0]  deq_o;
    logic [4:0]  out_valid_o;
    logic [14:0] out_sel_o;
    logic [4:0]  busy_o;
    logic [4:0]  wdog_err_o;

    switch_alloc dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .valid_i     (valid_i),
        .dest_i      (dest_i),
        .tail_i      (tail_i),
        .out_ready_i (out_ready_i),
        .deq_o       (deq_o),
        .out_valid_o (out_valid_o),
        .out_sel_o   (out_sel_o),
        .busy_o      (busy_o),
        .wdog_err_o  (wdog_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [4:0]  deq;
        logic [4:0]  ov;
        logic [4:0]  busy;
        logic [14:0] sel;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [2:0] PN = 3'd0, PS = 3'd1, PE = 3'd2, PW = 3'd3, PL = 3'd4;
    localparam logic [4:0] RDY = 5'b11111;

    // Pack five 3-bit fields, field 0 in the LSBs.
    function automatic logic [14:0] pk(input logic [2:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [4:0] edeq, eov, ebusy,
                            input logic [14:0] esel);
        exp_t e;
        e.deq = edeq; e.ov = eov; e.busy = ebusy; e.sel = esel; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t        e;
        logic [14:0] m;
        compare("sb_nonempty", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            m = '0;
            for (int o = 0; o < 5; o++) m[o*3 +: 3] = {3{e.busy[o]}};
            compare({e.tag, " deq"},  32'(deq_o),       32'(e.deq));
            compare({e.tag, " oval"}, 32'(out_valid_o), 32'(e.ov));
            compare({e.tag, " busy"}, 32'(busy_o),      32'(e.busy));
            compare({e.tag, " sel"},  32'(out_sel_o & m), 32'(e.sel & m));
            compare({e.tag, " wdog"}, 32'(wdog_err_o),  32'(0));
        end
    endtask

    // Drive one cycle of inputs just after a posedge, check at the negedge.
    task automatic cyc(input string tag, input logic [4:0] v, input logic [14:0] d,
                       input logic [4:0] t, input logic [4:0] r,
                       input logic [4:0] edeq, input logic [4:0] eov,
                       input logic [4:0] ebusy, input logic [14:0] esel);
        valid_i = v; dest_i = d; tail_i = t; out_ready_i = r;
        push_exp(tag, edeq, eov, ebusy, esel);
        @(negedge clk_i);
        check_front();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [14:0] d_e, d_l, d_p, d_b, d_s;
        d_e = pk(PE, PN, PN, PN, PN);
        d_l = pk(PL, PL, PN, PL, PN);
        d_p = pk(PS, PN, PW, PN, PN);
        d_b = pk(PE, PN, PN, 3'd6, PN);
        d_s = pk(PS, PN, PN, PN, PN);

        rst_n_i = 1'b0; valid_i = '0; dest_i = '0; tail_i = '0; out_ready_i = RDY;
        @(posedge clk_i);
        #1;

        // Held in reset with a request pending: nothing moves.
        cyc("rst0", 5'b00001, d_e, 5'b00001, RDY, '0, '0, '0, '0);
        cyc("rst1", 5'b00001, d_e, 5'b00001, RDY, '0, '0, '0, '0);
        rst_n_i = 1'b1;

        // Single-flit packet N -> E.
        cyc("sf_arb",  5'b00001, d_e, 5'b00001, RDY, '0, '0, '0, '0);
        cyc("sf_xfer", 5'b00001, d_e, 5'b00001, RDY, 5'b00001, 5'b00100, 5'b00100, pk(0, 0, PN, 0, 0));
        cyc("sf_idle", 5'b00000, d_e, 5'b00000, RDY, '0, '0, '0, '0);

        // N, S, W each send 3 flits to LOCAL: order N, S, W with one gap between.
        cyc("ct_arb", 5'b01011, d_l, 5'b00000, RDY, '0, '0, '0, '0);
        cyc("ct_n1",  5'b01011, d_l, 5'b00000, RDY, 5'b00001, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PN));
        cyc("ct_n2",  5'b01011, d_l, 5'b00000, RDY, 5'b00001, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PN));
        cyc("ct_n3",  5'b01011, d_l, 5'b00001, RDY, 5'b00001, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PN));
        cyc("ct_gap1", 5'b01010, d_l, 5'b00000, RDY, '0, '0, '0, '0);
        cyc("ct_s1",  5'b01010, d_l, 5'b00000, RDY, 5'b00010, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PS));
        cyc("ct_s2",  5'b01010, d_l, 5'b00000, RDY, 5'b00010, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PS));
        cyc("ct_s3",  5'b01010, d_l, 5'b00010, RDY, 5'b00010, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PS));
        cyc("ct_gap2", 5'b01000, d_l, 5'b00000, RDY, '0, '0, '0, '0);
        cyc("ct_w1",  5'b01000, d_l, 5'b00000, RDY, 5'b01000, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PW));
        cyc("ct_w2",  5'b01000, d_l, 5'b00000, RDY, 5'b01000, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PW));
        cyc("ct_w3",  5'b01000, d_l, 5'b01000, RDY, 5'b01000, 5'b10000, 5'b10000, pk(0, 0, 0, 0, PW));
        cyc("ct_end", 5'b00000, d_l, 5'b00000, RDY, '0, '0, '0, '0);

        // Backpressure on E for 4 cycles mid-packet.
        cyc("bp_arb", 5'b00001, d_e, 5'b00000, RDY, '0, '0, '0, '0);
        cyc("bp_f1",  5'b00001, d_e, 5'b00000, RDY, 5'b00001, 5'b00100, 5'b00100, pk(0, 0, PN, 0, 0));
        for (int i = 0; i < 4; i++)
            cyc("bp_hold", 5'b00001, d_e, 5'b00000, 5'b11011, '0, '0, 5'b00100, pk(0, 0, PN, 0, 0));
        cyc("bp_f2",  5'b00001, d_e, 5'b00000, RDY, 5'b00001, 5'b00100, 5'b00100, pk(0, 0, PN, 0, 0));
        cyc("bp_f3",  5'b00001, d_e, 5'b00001, RDY, 5'b00001, 5'b00100, 5'b00100, pk(0, 0, PN, 0, 0));
        cyc("bp_idle", 5'b00000, d_e, 5'b00000, RDY, '0, '0, '0, '0);

        // Parallel grants: N->S, E->W, L->N.
        cyc("pl_arb", 5'b10101, d_p, 5'b00000, RDY, '0, '0, '0, '0);
        cyc("pl_f1",  5'b10101, d_p, 5'b00000, RDY, 5'b10101, 5'b01011, 5'b01011, pk(PL, PN, 0, PE, 0));
        cyc("pl_f2",  5'b10101, d_p, 5'b10101, RDY, 5'b10101, 5'b01011, 5'b01011, pk(PL, PN, 0, PE, 0));
        cyc("pl_idle", 5'b00000, d_p, 5'b00000, RDY, '0, '0, '0, '0);

        // Bad dest code on W for 20 cycles while N still gets through to E.
        cyc("bd_arb",  5'b01001, d_b, 5'b00001, RDY, '0, '0, '0, '0);
        cyc("bd_nxfr", 5'b01001, d_b, 5'b00001, RDY, 5'b00001, 5'b00100, 5'b00100, pk(0, 0, PN, 0, 0));
        for (int i = 0; i < 18; i++)
            cyc("bd_hold", 5'b01000, d_b, 5'b00000, RDY, '0, '0, '0, '0);

        // Async reset in the middle of a N->S packet.
        cyc("ar_arb", 5'b00001, d_s, 5'b00000, RDY, '0, '0, '0, '0);
        cyc("ar_f1",  5'b00001, d_s, 5'b00000, RDY, 5'b00001, 5'b00010, 5'b00010, pk(0, PN, 0, 0, 0));
        valid_i = 5'b00001; dest_i = d_s; tail_i = '0; out_ready_i = RDY;
        #1 rst_n_i = 1'b0;
        #1;
        push_exp("ar_async", '0, '0, '0, '0);
        check_front();
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        cyc("ar_re_arb",  5'b00001, d_s, 5'b00001, RDY, '0, '0, '0, '0);
        cyc("ar_re_xfer", 5'b00001, d_s, 5'b00001, RDY, 5'b00001, 5'b00010, 5'b00010, pk(0, PN, 0, 0, 0));
        cyc("ar_re_idle", 5'b00000, d_s, 5'b00000, RDY, '0, '0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
